sobel_stream_ctrl: RTL



---
 rtl/sobel_pkg.sv | 14 +
 rtl/sobel_stream_ctrl_if.sv | 24 ++
 rtl/core_sobel.sv | 32 +++
 rtl/sobel_line_buf.sv | 25 ++
 rtl/sobel_stream_ctrl.sv | 128 ++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel streaming controller.
package sobel_pkg;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam pixel_t PIX_MAX = 8'hFF;

endpackage

// File: rtl/sobel_stream_ctrl_if.sv
// Pixel-in / gradient-out valid-ready streams of the Sobel controller.
// master = pixel source plus result sink, slave = the controller.
interface sobel_stream_ctrl_if;
  import sobel_pkg::*;

  logic   in_valid;
  logic   in_ready;
  pixel_t in_pixel;
  logic   out_valid;
  logic   out_ready;
  pixel_t out_pixel;
  logic   out_last;

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_last
  );

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_last
  );

endinterface

// File: rtl/core_sobel.sv
// Combinational Sobel gradient: |gx| + |gy| over a 3x3 window, saturated to 8 bits.
// The centre pixel (p4) does not contribute and is therefore not a port.
module core_sobel (
  input  logic [7:0] p0,
  input  logic [7:0] p1,
  input  logic [7:0] p2,
  input  logic [7:0] p3,
  input  logic [7:0] p5,
  input  logic [7:0] p6,
  input  logic [7:0] p7,
  input  logic [7:0] p8,
  output logic [7:0] mag
);

  logic [12:0] w_gx_pos, w_gx_neg, w_gy_pos, w_gy_neg;
  logic [12:0] w_gx, w_gy, w_gx_abs, w_gy_abs, w_sum;

  // Two's-complement differences in 13 bits; each weighted sum is at most 1020.
  always_comb begin
    w_gx_pos = {5'd0, p2} + {4'd0, p5, 1'b0} + {5'd0, p8};
    w_gx_neg = {5'd0, p0} + {4'd0, p3, 1'b0} + {5'd0, p6};
    w_gy_pos = {5'd0, p6} + {4'd0, p7, 1'b0} + {5'd0, p8};
    w_gy_neg = {5'd0, p0} + {4'd0, p1, 1'b0} + {5'd0, p2};
    w_gx     = w_gx_pos - w_gx_neg;
    w_gy     = w_gy_pos - w_gy_neg;
    w_gx_abs = w_gx[12] ? (13'd0 - w_gx) : w_gx;
    w_gy_abs = w_gy[12] ? (13'd0 - w_gy) : w_gy;
    w_sum    = w_gx_abs + w_gy_abs;
    mag      = (w_sum > 13'd255) ? 8'hFF : w_sum[7:0];
  end

endmodule

// File: rtl/sobel_line_buf.sv
// One line of pixels: synchronous write, combinational read at the same address,
// so the old value is read in the same cycle it is overwritten.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  pixel_t        i_wdata,
  output pixel_t        o_rdata
);

  pixel_t r_mem [DEPTH];

  // Write the new pixel for this column when a pixel is accepted.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sobel_stream_ctrl.sv
// Raster-order Sobel streaming controller: two line buffers plus a sliding
// window feed core_sobel; interior results leave one cycle after their pixel.
module sobel_stream_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 10,
  parameter int RW    = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  sobel_stream_ctrl_if.slave  stream,
  output logic                busy,
  output logic                frame_done
);

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  // Window columns 1 and 2 (top/mid/bot); column 0 is never needed after a shift.
  pixel_t        r_w1_t, r_w1_m, r_w1_b;
  pixel_t        r_w2_t, r_w2_m, r_w2_b;
  pixel_t        r_out_pixel;
  logic          r_out_valid, r_out_last;

  pixel_t        w_lb0_rd, w_lb1_rd, w_mag;
  logic          w_in_ready, w_busy, w_frame_done;
  logic          w_accept, w_col_last, w_row_last, w_interior;

  assign w_accept   = stream.in_valid & w_in_ready;
  assign w_col_last = (r_col == CW'(IMG_W - 1));
  assign w_row_last = (r_row == RW'(IMG_H - 1));
  // Also suppresses the stale columns left in the window across a line wrap.
  assign w_interior = (r_row >= RW'(2)) && (r_col >= CW'(2));

  // lb0 holds line row-2, lb1 holds line row-1 at the current column.
  sobel_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk(clk), .i_we(w_accept), .i_addr(r_col), .i_wdata(w_lb1_rd), .o_rdata(w_lb0_rd)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk(clk), .i_we(w_accept), .i_addr(r_col), .i_wdata(stream.in_pixel), .o_rdata(w_lb1_rd)
  );

  // Post-shift window: left = column 1, centre = column 2, right = incoming column.
  core_sobel u_core (
    .p0(r_w1_t), .p1(r_w2_t), .p2(w_lb0_rd),
    .p3(r_w1_m),              .p5(w_lb1_rd),
    .p6(r_w1_b), .p7(r_w2_b), .p8(stream.in_pixel),
    .mag(w_mag)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_accept && w_col_last && w_row_last) w_state_next = DRAIN;
      DRAIN:   if (r_out_valid && stream.out_ready && r_out_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: input backpressure follows the output register's occupancy.
  always_comb begin
    w_in_ready   = (r_state == RUN) && (!r_out_valid || stream.out_ready);
    w_busy       = (r_state == RUN);
    w_frame_done = (r_state == DRAIN) && r_out_valid && stream.out_ready && r_out_last;
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Shift the window left by one column on every accepted pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w1_t <= '0; r_w1_m <= '0; r_w1_b <= '0;
      r_w2_t <= '0; r_w2_m <= '0; r_w2_b <= '0;
    end else if (w_accept) begin
      r_w1_t <= r_w2_t;   r_w1_m <= r_w2_m;   r_w1_b <= r_w2_b;
      r_w2_t <= w_lb0_rd; r_w2_m <= w_lb1_rd; r_w2_b <= stream.in_pixel;
    end
  end

  // Output register: load an interior result, otherwise drain on out_ready, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept && w_interior) begin
      r_out_valid <= 1'b1;
      r_out_pixel <= w_mag;
      r_out_last  <= w_col_last && w_row_last;
    end else if (stream.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign stream.in_ready  = w_in_ready;
  assign stream.out_valid = r_out_valid;
  assign stream.out_pixel = r_out_pixel;
  assign stream.out_last  = r_out_last;
  assign busy             = w_busy;
  assign frame_done       = w_frame_done;

endmodule
